// File: rtl/rv32_rf_write_arbiter.sv
// Shares the RF write port: writeback wins, long-latency results bypass when idle or queue and drain into free slots.
// Bypass is 0 cycles; alt_ready drops when the queue is full without a pop, or while a starvation drain stalls the pipe.
module rv32_rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_ID_W   = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pipe_reg_write,
  input  logic [REG_ID_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0]   pipe_data,
  input  logic                alt_valid,
  input  logic [REG_ID_W-1:0] alt_rd,
  input  logic [DATA_W-1:0]   alt_data,
  output logic                alt_ready,
  output logic                pipe_stall,
  output logic                rf_we,
  output logic [REG_ID_W-1:0] rf_rd,
  output logic [DATA_W-1:0]   rf_wdata
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {NORMAL, FORCE_DRAIN} state_t;

  state_t                state_q;
  logic [FIFO_DEPTH-1:0] ent_vld_q;
  logic [REG_ID_W-1:0]   ent_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]     ent_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;
  logic [WAIT_W-1:0]     wait_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              head_vld;
  logic              any_vld;
  logic              pipe_grant;
  logic              squash_alt;
  logic              alt_drop;
  logic              pop;
  logic              pop_vld;
  logic              push;
  logic              bypass;
  logic [CNT_W-1:0]  count_d;
  logic [WAIT_W-1:0] wait_d;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    head_vld   = !fifo_empty && ent_vld_q[head_q];
    any_vld    = |ent_vld_q;
    pipe_grant = 1'b0;
    squash_alt = 1'b0;
    alt_drop   = 1'b0;
    pop        = 1'b0;
    pop_vld    = 1'b0;
    push       = 1'b0;
    bypass     = 1'b0;
    alt_ready  = 1'b0;
    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_wdata   = '0;

    if (state_q == NORMAL) begin
      pipe_grant = pipe_reg_write && (pipe_rd != '0);
      if (pipe_grant) begin
        rf_we    = 1'b1;
        rf_rd    = pipe_rd;
        rf_wdata = pipe_data;
        // A dead head entry needs no port slot, so it retires alongside the pipeline write.
        pop      = !fifo_empty && !ent_vld_q[head_q];
      end else if (head_vld) begin
        rf_we    = 1'b1;
        rf_rd    = ent_rd_q[head_q];
        rf_wdata = ent_data_q[head_q];
        pop      = 1'b1;
        pop_vld  = 1'b1;
      end else if (!fifo_empty) begin
        pop = 1'b1;
      end else if (alt_valid && (alt_rd != '0)) begin
        bypass   = 1'b1;
        rf_we    = 1'b1;
        rf_rd    = alt_rd;
        rf_wdata = alt_data;
      end

      // The pipeline write is younger, so a same-rd alt result is already stale.
      squash_alt = pipe_grant && (alt_rd == pipe_rd);
      alt_drop   = (alt_rd == '0) || squash_alt;
      alt_ready  = !fifo_full || pop || alt_drop || bypass;
      push       = alt_valid && !alt_drop && !bypass && (!fifo_full || pop);
    end else begin
      if (head_vld) begin
        rf_we    = 1'b1;
        rf_rd    = ent_rd_q[head_q];
        rf_wdata = ent_data_q[head_q];
        pop      = 1'b1;
        pop_vld  = 1'b1;
      end else if (!fifo_empty) begin
        pop = 1'b1;
      end
    end

    if (!resetn) begin
      rf_we     = 1'b0;
      alt_ready = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    wait_d  = wait_q;
    if ((state_q == FORCE_DRAIN) || pop_vld || fifo_empty) begin
      wait_d = '0;
    end else if (any_vld && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign pipe_stall = resetn && (state_q == FORCE_DRAIN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= NORMAL;
      ent_vld_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (pipe_grant && ent_vld_q[i] && (ent_rd_q[i] == pipe_rd)) begin
          ent_vld_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_vld_q[head_q] <= 1'b0;
        head_q            <= head_q + PTR_W'(1);
      end
      // Push follows pop so a full queue can retire and refill the same slot in one cycle.
      if (push) begin
        ent_vld_q[tail_q]  <= 1'b1;
        ent_rd_q[tail_q]   <= alt_rd;
        ent_data_q[tail_q] <= alt_data;
        tail_q             <= tail_q + PTR_W'(1);
      end
      count_q <= count_d;
      wait_q  <= wait_d;
      case (state_q)
        NORMAL:      if (wait_d == WAIT_MAX) state_q <= FORCE_DRAIN;
        FORCE_DRAIN: if (count_d == '0) state_q <= NORMAL;
        default:     state_q <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_rf_write_arbiter.sv
// Directed bench for rv32_rf_write_arbiter: per-cycle expected writes go into a scoreboard queue that a monitor drains.
module tb_rv32_rf_write_arbiter;
  logic        clk;
  logic        resetn;
  logic        pipe_reg_write;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        alt_valid;
  logic [4:0]  alt_rd;
  logic [31:0] alt_data;
  logic        alt_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  string       tag_q[$];
  logic [31:0] shadow [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  rv32_rf_write_arbiter #(
    .DATA_W(32), .REG_ID_W(5), .FIFO_DEPTH(2), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .alt_valid(alt_valid), .alt_rd(alt_rd), .alt_data(alt_data), .alt_ready(alt_ready),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, required 0x%0h", tag, what, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we !== 1'b0) begin
      shadow[rf_rd] = rf_wdata;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rf_we=%b rd=%0d data=0x%0h, required no write", rf_we, rf_rd, rf_wdata);
      end else begin
        wr_t   e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "rf_rd", 32'(rf_rd), 32'(e.rd));
        chk(t, "rf_wdata", rf_wdata, e.data);
      end
    end
  end

  task automatic step(input string tag,
                      input logic pw, input logic [4:0] prd, input logic [31:0] pdat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic ew, input logic [4:0] erd, input logic [31:0] edat,
                      input logic erdy, input logic estall);
    wr_t w;
    pipe_reg_write = pw;
    pipe_rd        = prd;
    pipe_data      = pdat;
    alt_valid      = av;
    alt_rd         = ard;
    alt_data       = adat;
    if (ew) begin
      w.rd   = erd;
      w.data = edat;
      exp_q.push_back(w);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    #1;
    chk(tag, "alt_ready", 32'(alt_ready), 32'(erdy));
    chk(tag, "pipe_stall", 32'(pipe_stall), 32'(estall));
    chk(tag, "write_missing", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic ew, input logic [4:0] erd, input logic [31:0] edat);
    step(tag, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ew, erd, edat, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    resetn         = 1'b1;
    pipe_reg_write = 1'b1;
    pipe_rd        = 5'd1;
    pipe_data      = 32'h5555;
    alt_valid      = 1'b1;
    alt_rd         = 5'd7;
    alt_data       = 32'h7777;
    #1 resetn = 1'b0;

    // Held in reset with live requests on both sides: nothing may be granted.
    @(negedge clk);
    #1;
    chk("reset", "rf_we", 32'(rf_we), 32'd0);
    chk("reset", "pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset", "alt_ready", 32'(alt_ready), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Bypass into an empty queue.
    step("bypass", 0, 5'd0, 32'h0, 1, 5'd7, 32'h1234, 1, 5'd7, 32'h1234, 1, 0);
    idle("bypass_empty", 0, 5'd0, 32'h0);

    // Queue behind three pipeline writes, drain in the first free slot.
    step("q0", 1, 5'd3, 32'h300, 1, 5'd9, 32'hAA, 1, 5'd3, 32'h300, 1, 0);
    step("q1", 1, 5'd3, 32'h301, 0, 5'd0, 32'h0,  1, 5'd3, 32'h301, 1, 0);
    step("q2", 1, 5'd3, 32'h302, 0, 5'd0, 32'h0,  1, 5'd3, 32'h302, 1, 0);
    idle("q_drain", 1, 5'd9, 32'hAA);
    idle("q_empty", 0, 5'd0, 32'h0);

    // Starvation: four blocked cycles, then one forced-drain cycle with the pipe stalled.
    step("s0", 1, 5'd1, 32'h100, 1, 5'd12, 32'hBEEF, 1, 5'd1, 32'h100, 1, 0);
    step("s1", 1, 5'd1, 32'h101, 0, 5'd0,  32'h0,    1, 5'd1, 32'h101, 1, 0);
    step("s2", 1, 5'd1, 32'h102, 0, 5'd0,  32'h0,    1, 5'd1, 32'h102, 1, 0);
    step("s3", 1, 5'd1, 32'h103, 0, 5'd0,  32'h0,    1, 5'd1, 32'h103, 1, 0);
    step("s4", 1, 5'd1, 32'h104, 0, 5'd0,  32'h0,    1, 5'd1, 32'h104, 1, 0);
    step("s5_force", 1, 5'd1, 32'h105, 1, 5'd13, 32'h13, 1, 5'd12, 32'hBEEF, 0, 1);
    step("s6_resume", 1, 5'd1, 32'h105, 1, 5'd13, 32'h13, 1, 5'd1, 32'h105, 1, 0);
    idle("s7_drain", 1, 5'd13, 32'h13);

    // WAW: a younger pipeline write kills the queued entry and a same-rd alt result.
    step("w0", 1, 5'd2, 32'h200, 1, 5'd5, 32'h11, 1, 5'd2, 32'h200, 1, 0);
    step("w1", 1, 5'd5, 32'h22,  0, 5'd0, 32'h0,  1, 5'd5, 32'h22,  1, 0);
    idle("w2_dead_pop", 0, 5'd0, 32'h0);
    idle("w3", 0, 5'd0, 32'h0);
    step("w4", 1, 5'd6, 32'h60, 1, 5'd6, 32'h66, 1, 5'd6, 32'h60, 1, 0);
    idle("w5", 0, 5'd0, 32'h0);

    // Full queue: back-pressure, then push and pop in one cycle at full.
    step("f0", 1, 5'd1, 32'hF0, 1, 5'd10, 32'hA0, 1, 5'd1,  32'hF0, 1, 0);
    step("f1", 1, 5'd1, 32'hF1, 1, 5'd11, 32'hA1, 1, 5'd1,  32'hF1, 1, 0);
    step("f2_full", 1, 5'd1, 32'hF2, 1, 5'd14, 32'hA4, 1, 5'd1, 32'hF2, 0, 0);
    step("f3_pushpop", 0, 5'd0, 32'h0, 1, 5'd14, 32'hA4, 1, 5'd10, 32'hA0, 1, 0);
    step("f4_still_full", 1, 5'd1, 32'hF4, 1, 5'd15, 32'hA5, 1, 5'd1, 32'hF4, 0, 0);
    idle("f5", 1, 5'd11, 32'hA1);
    idle("f6", 1, 5'd14, 32'hA4);
    idle("f7", 0, 5'd0, 32'h0);

    // x0 on both sides: no write, alt result accepted and dropped.
    step("x0", 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBAD, 0, 5'd0, 32'h0, 1, 0);
    idle("x0_after", 0, 5'd0, 32'h0);

    // Reset with two queued entries.
    step("r0", 1, 5'd1, 32'h1, 1, 5'd20, 32'h20, 1, 5'd1, 32'h1, 1, 0);
    step("r1", 1, 5'd1, 32'h2, 1, 5'd21, 32'h21, 1, 5'd1, 32'h2, 1, 0);
    resetn         = 1'b0;
    pipe_reg_write = 1'b0;
    alt_valid      = 1'b0;
    #1;
    chk("mid_reset", "rf_we", 32'(rf_we), 32'd0);
    chk("mid_reset", "pipe_stall", 32'(pipe_stall), 32'd0);
    chk("mid_reset", "alt_ready", 32'(alt_ready), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle("post_reset0", 0, 5'd0, 32'h0);
    idle("post_reset1", 0, 5'd0, 32'h0);

    chk("final", "x5", shadow[5], 32'h22);
    chk("final", "x6", shadow[6], 32'h60);
    chk("final", "x0", shadow[0], 32'h0);
    chk("final", "pending_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
